// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: first-word-fall-through result buffer for the FPU.
// Holds DEPTH {data, status} entries in a circular buffer, flags lost results
// with a sticky drop bit, and optionally accumulates status across results.
// Optional feature macro: FPU_RES_STICKY_EN adds the sticky_out port/register.
module fpu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       res_valid_in,
  input  logic [31:0]                data_in,
  input  logic [3:0]                 status_in,
  input  logic                       clear_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [31:0]                data_out,
  output logic [3:0]                 status_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       full_out,
  output logic                       drop_out
`ifdef FPU_RES_STICKY_EN
  ,
  output logic [3:0]                 sticky_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO_C = CW'(0);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO_C = AW'(0);
  localparam logic [3:0]    STICKY_INIT_C = 4'b1000;

  // Storage and control state
  logic [35:0]   mem_q [DEPTH];
  logic [35:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_q, drop_d;

  // Per-cycle handshake decisions
  logic          not_empty_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_event_s;
  logic [35:0]   head_s;

  // Sticky status merge: AND for EXACT, OR for the exception flags.
  function automatic logic [3:0] merge_status(input logic [3:0] acc,
                                              input logic [3:0] st);
    merge_status = {acc[3] & st[3], acc[2:0] | st[2:0]};
  endfunction

  // Handshake decode: a pop frees a slot for a same-cycle push when full.
  always_comb begin
    not_empty_s  = (count_q != CNT_ZERO_C);
    pop_s        = not_empty_s & out_ready;
    push_s       = res_valid_in & ((count_q != DEPTH_C) | pop_s);
    drop_event_s = res_valid_in & ~push_s;
    head_s       = mem_q[rd_ptr_q];
  end

  // Next-state for storage, pointers, occupancy and drop flag.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;

    if (push_s) begin
      mem_d[wr_ptr_q] = {data_in, status_in};
      wr_ptr_d        = wr_ptr_q + PTR_ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE_C;
      2'b01:   count_d = count_q - CNT_ONE_C;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as clear wins, so the loss is never hidden.
    if (clear_in) begin
      drop_d = drop_event_s;
    end else begin
      drop_d = drop_q | drop_event_s;
    end
  end

  // Control registers with synchronous reset taking priority over all traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO_C;
      rd_ptr_q <= PTR_ZERO_C;
      count_q  <= CNT_ZERO_C;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents are don't-care after reset since count gates them.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= mem_q;
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef FPU_RES_STICKY_EN
  logic [3:0] sticky_q, sticky_d;
  logic [3:0] sticky_base_s;

  // Sticky accumulation: clear restarts from the neutral value before merging.
  always_comb begin
    sticky_base_s = sticky_q;
    sticky_d      = sticky_q;
    if (clear_in) begin
      sticky_base_s = STICKY_INIT_C;
    end else begin
      sticky_base_s = sticky_q;
    end
    if (push_s) begin
      sticky_d = merge_status(sticky_base_s, status_in);
    end else begin
      sticky_d = sticky_base_s;
    end
  end

  // Sticky status register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= STICKY_INIT_C;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  // Sticky output straight from its register.
  always_comb begin
    sticky_out = sticky_q;
  end
`endif

  // Output drive: head entry falls through while valid, zeros otherwise.
  always_comb begin
    out_valid = not_empty_s;
    count_out = count_q;
    full_out  = (count_q == DEPTH_C);
    drop_out  = drop_q;
    if (not_empty_s) begin
      data_out   = head_s[35:4];
      status_out = head_s[3:0];
    end else begin
      data_out   = 32'h0000_0000;
      status_out = 4'b0000;
    end
  end

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Directed bench for fpu_result_fifo with a queue scoreboard and a small
// behavioural model of occupancy, drop and sticky status.
module tb_fpu_result_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid_in;
  logic [31:0] data_in;
  logic [3:0]  status_in;
  logic        clear_in;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic [2:0]  count_out;
  logic        full_out;
  logic        drop_out;
`ifdef FPU_RES_STICKY_EN
  logic [3:0]  sticky_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [35:0] exp_q[$];
  int          m_count = 0;
  logic        m_drop = 1'b0;
  logic [3:0]  m_sticky = 4'b1000;

  fpu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .res_valid_in(res_valid_in), .data_in(data_in),
    .status_in(status_in), .clear_in(clear_in), .out_ready(out_ready),
    .out_valid(out_valid), .data_out(data_out), .status_out(status_out),
    .count_out(count_out), .full_out(full_out), .drop_out(drop_out)
`ifdef FPU_RES_STICKY_EN
    , .sticky_out(sticky_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after the falling edge, check head before the
  // rising edge when a pop is due, update the model, check state after it.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [3:0] s,
                     input logic rdy, input logic clr, input logic rst);
    logic pop, push, drp;
    logic [3:0] base;
    @(negedge clk);
    reset = rst; res_valid_in = v; data_in = d; status_in = s;
    out_ready = rdy; clear_in = clr;
    #1;
    pop  = (m_count > 0) && rdy;
    push = v && ((m_count < DEPTH) || pop);
    drp  = v && !push;
    if (pop && !rst) begin
      chk("head_data", {4'h0, data_out}, {4'h0, exp_q[0][35:4]});
      chk("head_status", {32'h0, status_out}, {32'h0, exp_q[0][3:0]});
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      m_count = 0; m_drop = 1'b0; m_sticky = 4'b1000;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({d, s});
      if (push && !pop) m_count++;
      else if (pop && !push) m_count--;
      m_drop = clr ? drp : (m_drop | drp);
      base = clr ? 4'b1000 : m_sticky;
      m_sticky = push ? {base[3] & s[3], base[2:0] | s[2:0]} : base;
    end
    chk("count", 36'(count_out), 36'(m_count));
    chk("valid", 36'(out_valid), 36'(m_count > 0));
    chk("full", 36'(full_out), 36'(m_count == DEPTH));
    chk("drop", 36'(drop_out), 36'(m_drop));
    if (m_count > 0) chk("fwft", {data_out, status_out}, exp_q[0]);
    else             chk("idle_zero", {data_out, status_out}, 36'h0);
`ifdef FPU_RES_STICKY_EN
    chk("sticky", 36'(sticky_out), 36'(m_sticky));
`endif
  endtask

  task automatic push1(input logic [31:0] d, input logic [3:0] s);
    cyc(1'b1, d, s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 32'h0, 4'h0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; res_valid_in = 1'b0; data_in = 32'h0; status_in = 4'h0;
    clear_in = 1'b0; out_ready = 1'b0;

    // Reset state
    cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 36'(count_out), 36'h0);
    chk("rst_valid", 36'(out_valid), 36'h0);
    chk("rst_drop", 36'(drop_out), 36'h0);

    // Single push, one-cycle latency
    push1(32'h4000_0000, 4'b1000);
    chk("lat_data", 36'(data_out), 36'h4000_0000);
    chk("lat_status", 36'(status_out), 36'h8);
    chk("lat_count", 36'(count_out), 36'h1);
    idle(1'b1);

    // Fill, overflow drop, drain in order
    push1(32'h3f80_0000, 4'b0000);
    push1(32'h4000_0000, 4'b1000);
    push1(32'h4040_0000, 4'b0001);
    push1(32'hc000_0000, 4'b1000);
    push1(32'h7fc0_0000, 4'b0100);
    chk("ovf_full", 36'(full_out), 36'h1);
    chk("ovf_drop", 36'(drop_out), 36'h1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("clr_drop", 36'(drop_out), 36'h0);

    // Full with simultaneous push/pop across pointer wrap
    for (int i = 0; i < 4; i++) push1(32'h1000_0000 + 32'(i), 4'(i));
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 32'h2000_0000 + 32'(i), 4'(i + 3), 1'b1, 1'b0, 1'b0);
    chk("wrap_count", 36'(count_out), 36'h4);
    chk("wrap_drop", 36'(drop_out), 36'h0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Empty with push and ready together: push only
    cyc(1'b1, 32'h3f00_0000, 4'b0001, 1'b1, 1'b0, 1'b0);
    chk("empty_pp_count", 36'(count_out), 36'h1);
    idle(1'b1);

    // Clear coincident with a new drop keeps drop set
    for (int i = 0; i < 4; i++) push1(32'h5000_0000 + 32'(i), 4'b0010);
    cyc(1'b1, 32'hdead_beef, 4'b0010, 1'b0, 1'b1, 1'b0);
    chk("clr_drop_same", 36'(drop_out), 36'h1);
    idle(1'b1);

    // Reset with 3 entries stored and a push active
    cyc(1'b1, 32'h1234_5678, 4'b0001, 1'b0, 1'b0, 1'b1);
    chk("rst2_count", 36'(count_out), 36'h0);
    chk("rst2_valid", 36'(out_valid), 36'h0);
    chk("rst2_drop", 36'(drop_out), 36'h0);
    chk("rst2_data", 36'(data_out), 36'h0);

`ifdef FPU_RES_STICKY_EN
    chk("stk_init", 36'(sticky_out), 36'h8);
    cyc(1'b1, 32'h3f80_0000, 4'b1000, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h7f80_0000, 4'b0100, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h3eaa_aaab, 4'b0001, 1'b1, 1'b0, 1'b0);
    chk("stk_acc", 36'(sticky_out), 36'h5);
    cyc(1'b1, 32'h4000_0000, 4'b1000, 1'b1, 1'b1, 1'b0);
    chk("stk_clr", 36'(sticky_out), 36'h8);
`endif

    // Randomised traffic checked entirely by the scoreboard/model
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0), 1'b0);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
